// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings and
// the ready/start level names used by div_unit and its step datapath.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// Combinational restoring-division slice: retires BITS_PER_CYCLE quotient bits
// by chaining single-bit shift / trial-subtract stages, MSB first.
module div_step #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [DATA_W-1:0]         partial_rem,
  input  logic [BITS_PER_CYCLE-1:0] dvd_bits,
  input  logic [DATA_W-1:0]         divisor,
  output logic [DATA_W-1:0]         next_rem,
  output logic [BITS_PER_CYCLE-1:0] quo_bits
);

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_stage
    logic [DATA_W-1:0] rem_prev;
    logic [DATA_W-1:0] rem_out;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;

    if (gi == 0) begin : g_first
      assign rem_prev = partial_rem;
    end else begin : g_rest
      assign rem_prev = g_stage[gi-1].rem_out;
    end

    // partial remainder stays below the divisor, so the borrow bit alone
    // decides whether the trial subtraction succeeded
    assign trial = {rem_prev, dvd_bits[BITS_PER_CYCLE-1-gi]};
    assign diff  = trial - {1'b0, divisor};
    assign quo_bits[BITS_PER_CYCLE-1-gi] = ~diff[DATA_W];
    assign rem_out = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
  end

  assign next_rem = g_stage[BITS_PER_CYCLE-1].rem_out;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider, result = {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in one edge when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int K     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

  div_state_e state_reg, state_next;
  logic [DATA_W-1:0]   dvd_reg, dvd_next;
  logic [DATA_W-1:0]   dsr_reg, dsr_next;
  logic [DATA_W-1:0]   rem_reg, rem_next;
  logic [DATA_W-1:0]   quo_reg, quo_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                q_neg_reg, q_neg_next;
  logic                r_neg_reg, r_neg_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic                ready_reg, ready_next;

  logic                      op1_neg, op2_neg;
  logic [DATA_W-1:0]         op1_mag, op2_mag;
  logic [DATA_W-1:0]         step_rem, quo_shifted, final_quo, final_rem;
  logic [BITS_PER_CYCLE-1:0] step_quo_bits;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  div_step #(
    .DATA_W         (DATA_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .partial_rem (rem_reg),
    .dvd_bits    (dvd_reg[DATA_W-1 -: BITS_PER_CYCLE]),
    .divisor     (dsr_reg),
    .next_rem    (step_rem),
    .quo_bits    (step_quo_bits)
  );

  // MIN / -1 needs no special case: magnitude 2^(W-1) with positive sign
  // already encodes as MIN, and the remainder comes out zero
  assign quo_shifted = {quo_reg[DATA_W-BITS_PER_CYCLE-1:0], step_quo_bits};
  assign final_quo   = q_neg_reg ? -quo_shifted : quo_shifted;
  assign final_rem   = r_neg_reg ? -step_rem : step_rem;

  always_comb begin
    state_next  = state_reg;
    dvd_next    = dvd_reg;
    dsr_next    = dsr_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    cnt_next    = cnt_reg;
    q_neg_next  = q_neg_reg;
    r_neg_next  = r_neg_reg;
    result_next = result_reg;
    ready_next  = ready_reg;
    case (state_reg)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DivByZero;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (op1_mag < op2_mag) begin
            state_next  = DivEnd;
            result_next = {opdata1_i, {DATA_W{1'b0}}};
            ready_next  = DivResultReady;
          end
`endif
          else begin
            state_next = DivOn;
            dvd_next   = op1_mag;
            dsr_next   = op2_mag;
            rem_next   = '0;
            quo_next   = '0;
            cnt_next   = '0;
            q_neg_next = op1_neg ^ op2_neg;
            r_neg_next = op1_neg;
          end
        end
      end
      DivByZero: begin
        state_next  = DivEnd;
        result_next = '0;
        ready_next  = DivResultReady;
      end
      DivOn: begin
        if (annul_i || start_i == DivStop) begin
          state_next = DivFree;
        end else begin
          dvd_next = dvd_reg << BITS_PER_CYCLE;
          rem_next = step_rem;
          quo_next = quo_shifted;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_next  = DivEnd;
            result_next = {final_rem, final_quo};
            ready_next  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_next  = DivFree;
          result_next = '0;
          ready_next  = DivResultNotReady;
        end
      end
      default: state_next = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= DivFree;
      dvd_reg    <= '0;
      dsr_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      cnt_reg    <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      result_reg <= '0;
      ready_reg  <= DivResultNotReady;
    end else begin
      state_reg  <= state_next;
      dvd_reg    <= dvd_next;
      dsr_reg    <= dsr_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      cnt_reg    <= cnt_next;
      q_neg_reg  <= q_neg_next;
      r_neg_reg  <= r_neg_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule
